// File: rtl/ysyx_22050550_scoreboard_pkg.sv
// Shared sizing defaults and constants for the ID-stage register scoreboard.
package ysyx_22050550_scoreboard_pkg;

    localparam int DEF_NR_REG = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 2;

    localparam logic [DEF_REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/ysyx_22050550_sb_entry.sv
// One scoreboard cell: saturating up/down pending-write counter for a single GPR.
module ysyx_22050550_sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic             up;
    logic             down;

    assign up   = inc & ~dec;
    assign down = dec & ~inc;

    // Error pulse only: the top keeps it sticky. A flushed cycle discards the event.
    assign err  = ~flush & ((down & (cnt_q == '0)) | (up & (cnt_q == CNT_MAX)));
    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (up && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (down && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050550_scoreboard.sv
// Register scoreboard: RAW/WAW issue stall, WBU bypass grant, stall statistics.
// Optional forwarding enabled by defining SCOREBOARD_FWD_EN.
module ysyx_22050550_scoreboard
    import ysyx_22050550_scoreboard_pkg::*;
#(
    parameter int NR_REG = DEF_NR_REG,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_IDU_valid,
    input  logic [REG_AW-1:0] io_IDU_raddr1,
    input  logic              io_IDU_ren1,
    input  logic [REG_AW-1:0] io_IDU_raddr2,
    input  logic              io_IDU_ren2,
    input  logic [REG_AW-1:0] io_IDU_waddr,
    input  logic              io_IDU_wen,
    output logic              io_IDU_stall,
    output logic              io_IDU_fire,
    output logic              io_IDU_pass1,
    output logic              io_IDU_pass2,
    input  logic              io_WBU_valid,
    input  logic [REG_AW-1:0] io_WBU_waddr,
    input  logic              io_flush,
    output logic [NR_REG-1:0] io_busy,
    output logic [31:0]       io_stall_cnt,
    output logic              io_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REG_AW-1:0] REG_ZERO = ZERO_REG[REG_AW-1:0];

    logic [CNT_W-1:0]  cnt [NR_REG];
    logic [NR_REG-1:0] busy_vec;
    logic [NR_REG-1:0] err_vec;

    logic haz1, haz2, fwd1, fwd2, waw;
    logic stall, fire;
    logic [31:0] stall_cnt_q;
    logic        err_q;

    // x0 is hardwired: no cell, never busy, never errors.
    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;
    assign err_vec[0]  = 1'b0;

    for (genvar r = 1; r < NR_REG; r++) begin : g_entry
        ysyx_22050550_sb_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .clock(clock),
            .reset(reset),
            .inc  (fire & io_IDU_wen & (io_IDU_waddr == REG_AW'(r))),
            .dec  (io_WBU_valid & (io_WBU_waddr == REG_AW'(r))),
            .flush(io_flush),
            .cnt  (cnt[r]),
            .busy (busy_vec[r]),
            .err  (err_vec[r])
        );
    end

    always_comb begin
        haz1 = io_IDU_ren1 & busy_vec[io_IDU_raddr1];
        haz2 = io_IDU_ren2 & busy_vec[io_IDU_raddr2];
`ifdef SCOREBOARD_FWD_EN
        // Bypass is safe only when the retiring write is the last one outstanding.
        fwd1 = io_WBU_valid & (io_WBU_waddr == io_IDU_raddr1) &
               (io_IDU_raddr1 != REG_ZERO) & (cnt[io_IDU_raddr1] == CNT_ONE);
        fwd2 = io_WBU_valid & (io_WBU_waddr == io_IDU_raddr2) &
               (io_IDU_raddr2 != REG_ZERO) & (cnt[io_IDU_raddr2] == CNT_ONE);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        waw   = io_IDU_wen & (io_IDU_waddr != REG_ZERO) & (cnt[io_IDU_waddr] == CNT_MAX);
        stall = io_IDU_valid & ((haz1 & ~fwd1) | (haz2 & ~fwd2) | waw);
        fire  = io_IDU_valid & ~stall;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (|err_vec) begin
                err_q <= 1'b1;
            end
        end
    end

    assign io_IDU_stall = stall;
    assign io_IDU_fire  = fire;
    assign io_IDU_pass1 = io_IDU_valid & io_IDU_ren1 & (io_IDU_raddr1 != REG_ZERO) & fwd1;
    assign io_IDU_pass2 = io_IDU_valid & io_IDU_ren2 & (io_IDU_raddr2 != REG_ZERO) & fwd2;
    assign io_busy      = busy_vec;
    assign io_stall_cnt = stall_cnt_q;
    assign io_err       = err_q;

endmodule

// File: tb/tb_ysyx_22050550_scoreboard.sv
// Scenario-driven bench for the register scoreboard; expectations queued at drive time.
module tb_ysyx_22050550_scoreboard;

    logic        clock, reset;
    logic        io_IDU_valid, io_IDU_ren1, io_IDU_ren2, io_IDU_wen;
    logic [4:0]  io_IDU_raddr1, io_IDU_raddr2, io_IDU_waddr;
    logic        io_IDU_stall, io_IDU_fire, io_IDU_pass1, io_IDU_pass2;
    logic        io_WBU_valid;
    logic [4:0]  io_WBU_waddr;
    logic        io_flush;
    logic [31:0] io_busy;
    logic [31:0] io_stall_cnt;
    logic        io_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_stalls = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    ysyx_22050550_scoreboard dut (
        .clock(clock), .reset(reset),
        .io_IDU_valid(io_IDU_valid),
        .io_IDU_raddr1(io_IDU_raddr1), .io_IDU_ren1(io_IDU_ren1),
        .io_IDU_raddr2(io_IDU_raddr2), .io_IDU_ren2(io_IDU_ren2),
        .io_IDU_waddr(io_IDU_waddr), .io_IDU_wen(io_IDU_wen),
        .io_IDU_stall(io_IDU_stall), .io_IDU_fire(io_IDU_fire),
        .io_IDU_pass1(io_IDU_pass1), .io_IDU_pass2(io_IDU_pass2),
        .io_WBU_valid(io_WBU_valid), .io_WBU_waddr(io_WBU_waddr),
        .io_flush(io_flush), .io_busy(io_busy),
        .io_stall_cnt(io_stall_cnt), .io_err(io_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_idu(input logic v, input logic [4:0] r1, input logic e1,
                           input logic [4:0] r2, input logic e2,
                           input logic [4:0] wa, input logic we);
        io_IDU_valid = v;
        io_IDU_raddr1 = r1; io_IDU_ren1 = e1;
        io_IDU_raddr2 = r2; io_IDU_ren2 = e2;
        io_IDU_waddr = wa;  io_IDU_wen = we;
    endtask

    task automatic set_wbu(input logic v, input logic [4:0] a);
        io_WBU_valid = v; io_WBU_waddr = a;
    endtask

    task automatic idle();
        set_idu(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wbu(1'b0, 5'd0);
        io_flush = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        set_idu(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL reset_busy: got %h want %h", io_busy, e); end
        e = exp_q.pop_front(); n_cmp++; if (io_stall_cnt !== e) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want %0d", io_stall_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL reset_err: got %b want %0d", io_err, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL reset_stall: got %b want %0d", io_IDU_stall, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL reset_fire: got %b want %0d", io_IDU_fire, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_pass1) !== e) begin n_bad++; $display("FAIL reset_pass1: got %b want %0d", io_IDU_pass1, e); end
        cyc();
        reset = 1'b1;
        idle();
    endtask

    task automatic test_raw();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL raw_issue_fire: got %b want %0d", io_IDU_fire, e); end
        cyc();
        set_idu(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'h20);
        exp_stalls++;
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL raw_stall: got %b want %0d", io_IDU_stall, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL raw_fire: got %b want %0d", io_IDU_fire, e); end
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL raw_busy: got %h want %h", io_busy, e); end
        cyc();
        idle();
        exp_q.push_back(32'(exp_stalls));
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_stall_cnt !== e) begin n_bad++; $display("FAIL raw_stall_cnt: got %0d want %0d", io_stall_cnt, e); end
        cyc();
    endtask

    task automatic test_forward();
        set_idu(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        set_wbu(1'b1, 5'd5);
`ifdef SCOREBOARD_FWD_EN
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
`else
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_stalls++;
`endif
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL fwd_stall: got %b want %0d", io_IDU_stall, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_pass2) !== e) begin n_bad++; $display("FAIL fwd_pass2: got %b want %0d", io_IDU_pass2, e); end
        cyc();
        set_wbu(1'b0, 5'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL fwd_busy_after: got %h want %h", io_busy, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL fwd_fire_after: got %b want %0d", io_IDU_fire, e); end
        cyc();
        idle();
    endtask

    task automatic test_waw();
        for (int i = 0; i < 3; i++) begin
            set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
            exp_q.push_back(32'd1);
            mid();
            e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL waw_fill_fire%0d: got %b want %0d", i, io_IDU_fire, e); end
            cyc();
        end
        exp_q.push_back(32'd1);
        exp_stalls++;
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL waw_stall: got %b want %0d", io_IDU_stall, e); end
        cyc();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'h80);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL waw_err: got %b want %0d", io_err, e); end
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL waw_busy: got %h want %h", io_busy, e); end
        cyc();
        set_wbu(1'b1, 5'd7);
        cyc(); cyc();
        idle();
        exp_q.push_back(32'h80);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL waw_busy_cnt1: got %h want %h", io_busy, e); end
        cyc();
        set_wbu(1'b1, 5'd7);
        cyc();
        idle();
        exp_q.push_back(32'd0);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL waw_drained: got %h want %h", io_busy, e); end
        cyc();
    endtask

    task automatic test_back_to_back();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        cyc();
        set_wbu(1'b1, 5'd9);
        exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL b2b_fire_retire: got %b want %0d", io_IDU_fire, e); end
        cyc();
        set_wbu(1'b0, 5'd0);
        cyc();
        set_idu(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wbu(1'b1, 5'd9);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        exp_stalls++;
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL b2b_cnt2_stall: got %b want %0d", io_IDU_stall, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_pass1) !== e) begin n_bad++; $display("FAIL b2b_cnt2_pass1: got %b want %0d", io_IDU_pass1, e); end
        cyc();
        idle();
        exp_q.push_back(32'h200);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL b2b_busy_cnt1: got %h want %h", io_busy, e); end
        cyc();
        set_wbu(1'b1, 5'd9);
        cyc();
        idle();
        exp_q.push_back(32'd0);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL b2b_busy_free: got %h want %h", io_busy, e); end
        cyc();
    endtask

    task automatic test_err_x0();
        set_idu(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        set_wbu(1'b1, 5'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_stall) !== e) begin n_bad++; $display("FAIL x0_stall: got %b want %0d", io_IDU_stall, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL x0_fire: got %b want %0d", io_IDU_fire, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_pass1) !== e) begin n_bad++; $display("FAIL x0_pass1: got %b want %0d", io_IDU_pass1, e); end
        cyc();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL x0_busy: got %h want %h", io_busy, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL x0_err: got %b want %0d", io_err, e); end
        cyc();
        set_wbu(1'b1, 5'd12);
        cyc();
        idle();
        exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL err_set: got %b want %0d", io_err, e); end
        cyc(); cyc();
        exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL err_sticky: got %b want %0d", io_err, e); end
        cyc();
    endtask

    task automatic test_flush_reset();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        cyc();
        idle();
        exp_q.push_back(32'h18);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL flush_pre_busy: got %h want %h", io_busy, e); end
        cyc();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        set_wbu(1'b1, 5'd3);
        io_flush = 1'b1;
        cyc();
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'(exp_stalls)); exp_q.push_back(32'd1);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL flush_busy: got %h want %h", io_busy, e); end
        e = exp_q.pop_front(); n_cmp++; if (io_stall_cnt !== e) begin n_bad++; $display("FAIL flush_stall_cnt: got %0d want %0d", io_stall_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL flush_err: got %b want %0d", io_err, e); end
        cyc();
        set_idu(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        cyc();
        idle();
        exp_q.push_back(32'h100);
        mid();
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL midrst_pre_busy: got %h want %h", io_busy, e); end
        cyc();
        set_idu(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        #1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        e = exp_q.pop_front(); n_cmp++; if (io_busy !== e) begin n_bad++; $display("FAIL midrst_busy: got %h want %h", io_busy, e); end
        e = exp_q.pop_front(); n_cmp++; if (io_stall_cnt !== e) begin n_bad++; $display("FAIL midrst_stall_cnt: got %0d want %0d", io_stall_cnt, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_err) !== e) begin n_bad++; $display("FAIL midrst_err: got %b want %0d", io_err, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(io_IDU_fire) !== e) begin n_bad++; $display("FAIL midrst_fire: got %b want %0d", io_IDU_fire, e); end
        cyc();
        reset = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_forward();
        test_waw();
        test_back_to_back();
        test_err_x0();
        test_flush_reset();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
